// File: rtl/apb_pkg.sv
// Shared types and constants for the APB3 master bridge.
// Optional build macro used by the bridge: APB_TIMEOUT_EN.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  localparam logic [31:0] ERR_RDATA  = 32'h0;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Word transfers only: any set byte-offset bit is rejected before the bus.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response channel plus APB master bus of the bridge.
// The master modport is the bridge side; slave is the requester/bus side.
interface apb_master_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

endinterface

// File: rtl/apb_wdog_cnt.sv
// ACCESS-phase stall counter; expire_c fires on the cycle the count reaches LIMIT.
module apb_wdog_cnt #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // This increment would make the count equal LIMIT.
  assign expire_c = en && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: valid/ready request -> SETUP/ACCESS -> response.
// Build macro APB_TIMEOUT_EN adds a stalled-slave abort and sticky timeout_flag.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
`ifdef APB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_master_bridge_if.master bus,
  output logic                timeout_flag
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              psel_q, penable_q, rsp_valid_q, req_ready_q;
  logic              wdog_expire_c;

  // Next-state and captured-data logic.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          paddr_d  = bus.req_addr;
          pwrite_d = bus.req_write;
          pwdata_d = bus.req_wdata;
          if (is_misaligned(bus.req_addr[1:0])) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = DATA_W'(ERR_RDATA);
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.PREADY) begin
          state_d = ST_RESP;
          err_d   = bus.PSLVERR;
          rdata_d = (pwrite_q || bus.PSLVERR) ? DATA_W'(ERR_RDATA) : bus.PRDATA;
        end else if (wdog_expire_c) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = DATA_W'(ERR_RDATA);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered state; control outputs are decoded from the next state.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      psel_q      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_q   <= (state_d == ST_ACCESS);
      rsp_valid_q <= (state_d == ST_RESP);
      req_ready_q <= (state_d == ST_IDLE);
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;

`ifdef APB_TIMEOUT_EN
  logic flag_q;

  apb_wdog_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (PCLK),
    .rst      (PRESET),
    .clr      (state_q == ST_SETUP),
    .en       ((state_q == ST_ACCESS) && !bus.PREADY),
    .expire_c (wdog_expire_c)
  );

  // Sticky until reset; only an actual abort sets it.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      flag_q <= 1'b0;
    end else if (wdog_expire_c) begin
      flag_q <= 1'b1;
    end
  end

  assign timeout_flag = flag_q;
`else
  assign wdog_expire_c = 1'b0;
  assign timeout_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: vector table plus back-pressure, timeout and reset sequences.
module tb_apb_master_bridge;

  logic PCLK;
  logic PRESET;
  logic timeout_flag;

  apb_master_bridge_if bus ();

`ifdef APB_TIMEOUT_EN
  apb_master_bridge #(.TIMEOUT_CYCLES(16)) dut (
`else
  apb_master_bridge dut (
`endif
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .bus          (bus.master),
    .timeout_flag (timeout_flag)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    int          ws;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_setup;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  // Slave model configuration.
  int          ws_cfg     = 0;
  logic [31:0] prdata_cfg = 32'h0;
  logic        slverr_cfg = 1'b0;
  int          acc        = 0;

  // Slave: completes after ws_cfg wait states; outside ACCESS it drives junk the bridge must ignore.
  always @(negedge PCLK) begin
    if (bus.PSEL && bus.PENABLE) begin
      if (acc >= ws_cfg) begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = slverr_cfg;
        bus.PRDATA  = prdata_cfg;
      end else begin
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 32'hDEAD_BEEF;
      end
      acc = acc + 1;
    end else begin
      acc         = 0;
      bus.PREADY  = 1'b1;
      bus.PSLVERR = 1'b1;
      bus.PRDATA  = 32'hFFFF_FFFF;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One full transfer; cycle 0 is the cycle in which the request is presented.
  task automatic run_vec(input string tag, input vec_t v);
    int          first_sel = 0;
    int          first_en  = 0;
    int          lat       = 0;
    int          hold_bad  = 0;
    logic [31:0] rdata     = 32'h0;
    logic        err       = 1'b0;
    @(negedge PCLK);
    ws_cfg        = v.ws;
    prdata_cfg    = v.prdata;
    slverr_cfg    = v.slverr;
    bus.req_valid = 1'b1;
    bus.req_addr  = v.addr;
    bus.req_write = v.write;
    bus.req_wdata = v.wdata;
    bus.rsp_ready = 1'b1;
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, " psel_idle"}, 32'(bus.PSEL), 32'd0);
    for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
      @(negedge PCLK);
      if (cyc == 1) bus.req_valid = 1'b0;
      if (bus.PSEL && first_sel == 0) first_sel = cyc;
      if (bus.PENABLE && first_en == 0) first_en = cyc;
      if (bus.PSEL && (bus.PADDR !== v.addr || bus.PWRITE !== v.write || bus.PWDATA !== v.wdata))
        hold_bad++;
      if (bus.rsp_valid) begin
        lat   = cyc;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, " rdata"}, rdata, v.exp_rdata);
    check({tag, " err"}, 32'(err), 32'(v.exp_err));
    check({tag, " setup_cycle"}, 32'(first_sel), 32'(v.exp_setup));
    check({tag, " access_cycle"}, 32'(first_en), (v.exp_setup == 0) ? 32'd0 : 32'(v.exp_setup + 1));
    check({tag, " addr_hold"}, 32'(hold_bad), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int          bad;
    logic [31:0] held;
    vec_t        tv;

    vecs[0] = '{32'h6400_0010, 1'b1, 32'hA5A5_5A5A, 0, 32'h1111_2222, 1'b0, 32'h0,         1'b0, 3, 1};
    vecs[1] = '{32'h6800_0004, 1'b0, 32'h0,         3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 6, 1};
    vecs[2] = '{32'h7000_0000, 1'b0, 32'h0,         0, 32'h0BAD_F00D, 1'b1, 32'h0,         1'b1, 3, 1};
    vecs[3] = '{32'h6400_0002, 1'b1, 32'h1357_9BDF, 0, 32'h0,         1'b0, 32'h0,         1'b1, 1, 0};
    vecs[4] = '{32'h6400_0008, 1'b0, 32'h7777_0000, 1, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 4, 1};
    vecs[5] = '{32'h6400_000C, 1'b1, 32'h0102_0304, 2, 32'h5555_5555, 1'b1, 32'h0,         1'b1, 5, 1};
    vecs[6] = '{32'h6800_0001, 1'b0, 32'h0,         0, 32'h0,         1'b0, 32'h0,         1'b1, 1, 0};

    PRESET        = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_write = 1'b0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;

    check("rst req_ready", 32'(bus.req_ready), 32'd1);
    check("rst psel", 32'(bus.PSEL), 32'd0);
    check("rst penable", 32'(bus.PENABLE), 32'd0);
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst paddr", bus.PADDR, 32'h0);
    check("rst pwrite", 32'(bus.PWRITE), 32'd0);
    check("rst timeout_flag", 32'(timeout_flag), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Response back-pressure with a second request already waiting.
    @(negedge PCLK);
    ws_cfg        = 0;
    prdata_cfg    = 32'h55AA_1234;
    slverr_cfg    = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h6400_0020;
    bus.req_write = 1'b0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge PCLK);
    check("bp rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp rdata", bus.rsp_rdata, 32'h55AA_1234);
    held = bus.rsp_rdata;
    bad  = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge PCLK);
      if (!bus.rsp_valid || bus.rsp_rdata !== held || bus.rsp_err || bus.req_ready || bus.PSEL) bad++;
    end
    check("bp stall_stable", 32'(bad), 32'd0);
    @(negedge PCLK);
    bus.rsp_ready = 1'b1;
    bus.req_addr  = 32'h6400_0024;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'h0F0F_0F0F;
    @(negedge PCLK);
    check("bp gap req_ready", 32'(bus.req_ready), 32'd1);
    check("bp gap psel", 32'(bus.PSEL), 32'd0);
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    check("bp second psel", 32'(bus.PSEL), 32'd1);
    check("bp second paddr", bus.PADDR, 32'h6400_0024);
    repeat (2) @(negedge PCLK);
    check("bp second rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp second rdata", bus.rsp_rdata, 32'h0);
    check("bp second err", 32'(bus.rsp_err), 32'd0);

`ifdef APB_TIMEOUT_EN
    // PREADY on the 16th ACCESS cycle beats the abort.
    tv = '{32'h6800_000C, 1'b0, 32'h0, 15, 32'h0600_D000, 1'b0, 32'h0600_D000, 1'b0, 18, 1};
    run_vec("to_race", tv);
    check("to_race flag", 32'(timeout_flag), 32'd0);
    tv = '{32'h6800_0010, 1'b0, 32'h0, 1000, 32'h0, 1'b0, 32'h0, 1'b1, 18, 1};
    run_vec("to_abort", tv);
    check("to_abort flag", 32'(timeout_flag), 32'd1);
    tv = '{32'h6800_0014, 1'b0, 32'h0, 0, 32'h4242_4242, 1'b0, 32'h4242_4242, 1'b0, 3, 1};
    run_vec("to_after", tv);
    check("to_after flag", 32'(timeout_flag), 32'd1);
`else
    tv = '{32'h6400_0030, 1'b0, 32'h0, 0, 32'hABCD_0123, 1'b0, 32'hABCD_0123, 1'b0, 3, 1};
    run_vec("plain", tv);
    check("plain flag", 32'(timeout_flag), 32'd0);
`endif

    // Reset during the second ACCESS cycle of a stalled read.
    @(negedge PCLK);
    ws_cfg        = 1000;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h6800_0008;
    bus.req_write = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    check("mid penable", 32'(bus.PENABLE), 32'd1);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("mid rst psel", 32'(bus.PSEL), 32'd0);
    check("mid rst penable", 32'(bus.PENABLE), 32'd0);
    check("mid rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid rst flag", 32'(timeout_flag), 32'd0);
    PRESET = 1'b0;
    ws_cfg = 0;
    bad    = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      if (bus.rsp_valid || !bus.req_ready || bus.PSEL) bad++;
    end
    check("mid post_reset idle", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
